// File: rtl/sync_filter_pkg.sv
// ============================================================================
// sync_filter_pkg : shared constants and helpers for the sync_filter block
// Revision : 1.0
// ============================================================================
`default_nettype none

package sync_filter_pkg;

  localparam int MIN_FLOPS  = 2;
  localparam int MIN_STABLE = 1;

  // Counter must hold 0..STABLE-1; one spare code keeps STABLE=1 at 1 bit.
  function automatic int cnt_width(input int stable);
    return (stable < 1) ? 1 : $clog2(stable + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_filter_chan.sv
// ============================================================================
// sync_filter_chan : one channel - synchroniser chain, debounce counter,
//                    filtered level, edge pulses, optional sticky flag
//                    (SYNC_FILTER_STICKY_EN)
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_filter_chan
  import sync_filter_pkg::*;
#(
  parameter int   FLOPS   = 2,
  parameter int   STABLE  = 4,
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic data,
  output logic sync,
  output logic rise,
  output logic fall
`ifdef SYNC_FILTER_STICKY_EN
  ,
  input  logic clr,
  output logic changed
`endif
);

  localparam int                CNT_W   = cnt_width(STABLE);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE - 1);

  logic [FLOPS-1:0] chain_q, chain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_q, sync_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             s;

  assign s = chain_q[FLOPS-1];

  always_comb begin
    chain_d = {chain_q[FLOPS-2:0], data};
    cnt_d   = cnt_q;
    sync_d  = sync_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en) begin
      // Any reversion to the accepted level discards the partial count.
      if (s == sync_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        sync_d = s;
        cnt_d  = '0;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain_q <= {FLOPS{RST_BIT}};
      cnt_q   <= '0;
      sync_q  <= RST_BIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sync = sync_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef SYNC_FILTER_STICKY_EN
  logic changed_q, changed_d;

  // A pulse arriving with a clear wins, so no event is lost.
  always_comb begin
    changed_d = (changed_q & ~clr) | rise_q | fall_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign changed = changed_q;
`endif

endmodule

`default_nettype wire

// File: rtl/sync_filter.sv
// ============================================================================
// sync_filter : WIDTH-channel synchroniser + debounce filter with edge pulses
//               optional sticky change flags via SYNC_FILTER_STICKY_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_filter
  import sync_filter_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               FLOPS   = 2,
  parameter int               STABLE  = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`ifdef SYNC_FILTER_STICKY_EN
  ,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] changed
`endif
);

  if (FLOPS < MIN_FLOPS) begin : g_bad_flops
    $error("sync_filter: FLOPS must be >= %0d", MIN_FLOPS);
  end

  if (STABLE < MIN_STABLE) begin : g_bad_stable
    $error("sync_filter: STABLE must be >= %0d", MIN_STABLE);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
`ifdef SYNC_FILTER_STICKY_EN
    sync_filter_chan #(
      .FLOPS   (FLOPS),
      .STABLE  (STABLE),
      .RST_BIT (RST_VAL[i])
    ) u_chan (
      .clk     (clk),
      .rstn    (rstn),
      .en      (en),
      .data    (data[i]),
      .sync    (sync[i]),
      .rise    (rise[i]),
      .fall    (fall[i]),
      .clr     (clr[i]),
      .changed (changed[i])
    );
`else
    sync_filter_chan #(
      .FLOPS   (FLOPS),
      .STABLE  (STABLE),
      .RST_BIT (RST_VAL[i])
    ) u_chan (
      .clk     (clk),
      .rstn    (rstn),
      .en      (en),
      .data    (data[i]),
      .sync    (sync[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_filter.sv
// ============================================================================
// tb_sync_filter : randomized + directed self-checking bench for sync_filter
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sync_filter;

  localparam int         WIDTH   = 4;
  localparam int         FLOPS   = 2;
  localparam int         STABLE  = 4;
  localparam logic [3:0] RST_VAL = 4'b0101;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       en   = 1'b1;
  logic [3:0] data = 4'b0000;
  logic [3:0] sync, rise, fall;
`ifdef SYNC_FILTER_STICKY_EN
  logic [3:0] clr = 4'b0000;
  logic [3:0] changed;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sync_filter #(
    .WIDTH   (WIDTH),
    .FLOPS   (FLOPS),
    .STABLE  (STABLE),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .data    (data),
    .sync    (sync),
    .rise    (rise),
    .fall    (fall)
`ifdef SYNC_FILTER_STICKY_EN
    ,
    .clr     (clr),
    .changed (changed)
`endif
  );

  // Reference model: a FLOPS-long delay line feeding, per channel, a count of
  // consecutive enabled cycles in which the delayed input differs from the
  // accepted level; reaching STABLE accepts the new level.
  logic [3:0] m_pipe[$];
  logic [3:0] m_sync, m_rise, m_fall;
  int         m_run[4];
`ifdef SYNC_FILTER_STICKY_EN
  logic [3:0] m_changed;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pipe.delete();
    for (int i = 0; i < FLOPS; i++) m_pipe.push_front(RST_VAL);
    m_sync = RST_VAL;
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
`ifdef SYNC_FILTER_STICKY_EN
    m_changed = '0;
`endif
  endtask

  task automatic m_step(input logic [3:0] d, input logic e);
    logic [3:0] s;
    s = m_pipe.pop_back();
    m_pipe.push_front(d);
`ifdef SYNC_FILTER_STICKY_EN
    m_changed = (m_changed & ~clr) | m_rise | m_fall;
`endif
    m_rise = '0;
    m_fall = '0;
    if (e) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i] != m_sync[i]) begin
          m_run[i]++;
          if (m_run[i] == STABLE) begin
            m_sync[i] = s[i];
            if (s[i]) m_rise[i] = 1'b1;
            else      m_fall[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("sync", {28'd0, sync}, {28'd0, m_sync});
    chk("rise", {28'd0, rise}, {28'd0, m_rise});
    chk("fall", {28'd0, fall}, {28'd0, m_fall});
    chk("excl", {28'd0, rise & fall}, 32'd0);
`ifdef SYNC_FILTER_STICKY_EN
    chk("changed", {28'd0, changed}, {28'd0, m_changed});
`endif
  endtask

  // One clock: apply inputs, advance model at the edge, compare 1ns later.
  task automatic tick(input logic [3:0] d, input logic e);
    data = d;
    en   = e;
    @(posedge clk);
    if (!rstn) m_reset();
    else       m_step(d, e);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    m_reset();
    #1;
    compare_all();
    for (int i = 0; i < n; i++) tick(data, en);
    rstn = 1'b1;
  endtask

  // Counts clocks until sync[ch] flips; bounded so a stuck DUT still ends.
  task automatic wait_change(input int ch, input int exp_n, input string tag,
                             input logic [3:0] d, input logic e);
    logic start;
    int   n;
    start = sync[ch];
    n = 0;
    do begin
      tick(d, e);
      n++;
    end while (sync[ch] == start && n < 40);
    chk(tag, n, exp_n);
  endtask

  initial begin
    logic [3:0] d;
    logic       e;

    // Reset held for 5 cycles.
    m_reset();
    for (int i = 0; i < 5; i++) tick(4'b0000, 1'b1);
    chk("rst_sync", {28'd0, sync}, 32'h5);
    chk("rst_pulse", {28'd0, rise | fall}, 32'h0);
    rstn = 1'b1;

    // Settle all inputs low: channels 0 and 2 fall.
    for (int i = 0; i < 10; i++) tick(4'b0000, 1'b1);
    chk("settle", {28'd0, sync}, 32'h0);

    // Clean rising edge on channel 0.
    wait_change(0, FLOPS + STABLE, "lat_clean", 4'b0001, 1'b1);
    chk("rise0", {31'd0, rise[0]}, 32'd1);
    tick(4'b0001, 1'b1);
    chk("rise0_end", {31'd0, rise[0]}, 32'd0);

    // Glitch on channel 1: high for STABLE-1 cycles only.
    for (int i = 0; i < STABLE - 1; i++) tick(4'b0011, 1'b1);
    for (int i = 0; i < 8; i++) tick(4'b0001, 1'b1);
    chk("glitch", {31'd0, sync[1]}, 32'd0);

    // Enable gating on channel 2.
    for (int i = 0; i < 8; i++) tick(4'b0101, 1'b1);
    for (int i = 0; i < 10; i++) tick(4'b0001, 1'b0);
    chk("en_hold", {31'd0, sync[2]}, 32'd1);
    wait_change(2, STABLE, "lat_en", 4'b0001, 1'b1);
    chk("fall2", {31'd0, fall[2]}, 32'd1);

    // Multi-channel change with a reset landing mid-filter.
    for (int i = 0; i < 8; i++) tick(4'b0000, 1'b1);
    tick(4'b1111, 1'b1);
    tick(4'b1111, 1'b1);
    do_reset(2);
    chk("mid_rst", {28'd0, sync}, 32'h5);
    wait_change(1, FLOPS + STABLE, "lat_multi", 4'b1111, 1'b1);
    chk("multi_rise", {28'd0, rise}, 32'ha);

`ifdef SYNC_FILTER_STICKY_EN
    // Sticky flag: clear coinciding with a pulse keeps it set, later clear wins.
    for (int i = 0; i < 4; i++) tick(4'b1111, 1'b1);
    clr = 4'b1111;
    tick(4'b1111, 1'b1);
    clr = 4'b0000;
    wait_change(3, FLOPS + STABLE, "lat_sticky", 4'b0111, 1'b1);
    clr = 4'b1000;
    tick(4'b0111, 1'b1);
    chk("sticky_set", {31'd0, changed[3]}, 32'd1);
    tick(4'b0111, 1'b1);
    chk("sticky_clr", {31'd0, changed[3]}, 32'd0);
    clr = 4'b0000;
`endif

    // Randomized phase: frequent toggles produce both glitches and accepts.
    d = data;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) d[$urandom_range(0, 3)] ^= 1'b1;
      e = ($urandom_range(0, 9) != 0);
`ifdef SYNC_FILTER_STICKY_EN
      clr = 4'($urandom);
`endif
      if ($urandom_range(0, 299) == 0) begin
        data = d;
        do_reset(2);
      end else begin
        tick(d, e);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
